ipsl_pcie_ext_rcvd_ram_rd_ctrl: RTL and testbench

//  Read-side engine for the PCIe receive-payload SDP RAM. Accepts (start address, length) commands
//  and issues read addresses into the RAM. The RAM read latency is fixed at 2 cycles (registered

---
 rtl/ipsl_pcie_ext_rcvd_ram_rd_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_ipsl_pcie_ext_rcvd_ram_rd_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ipsl_pcie_ext_rcvd_ram_rd_ctrl.sv
// ipsl_pcie_ext_rcvd_ram_rd_ctrl
// Read engine for the PCIe receive-payload SDP RAM. Turns (addr, len) commands
// into RAM read addresses, tracks reads in flight through the fixed-latency RAM
// with a tag shift register, and returns the words through a small credit-limited
// prefetch FIFO as a valid/ready stream with a last flag.
module ipsl_pcie_ext_rcvd_ram_rd_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 72,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH:0]   cmd_len,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int INF_W = $clog2(RD_LATENCY + 1);
  localparam int SUM_W = $clog2(FIFO_DEPTH + RD_LATENCY + 1);
  localparam int LEN_W = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                  state_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [LEN_W-1:0]        issue_cnt_r;
  logic [LEN_W-1:0]        beat_cnt_r;
  logic                    cmd_ready_r;
  logic                    busy_r;
  logic                    done_r;
  logic [RD_LATENCY-1:0]   tag_r;
  logic [DATA_WIDTH-1:0]   mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_r;
  logic [PTR_W-1:0]        rd_ptr_r;
  logic [CNT_W-1:0]        fifo_count_r;
  logic                    valid_r;
  logic                    last_r;
  logic [DATA_WIDTH-1:0]   data_r;

  logic                    accept_s;
  logic                    issue_s;
  logic                    push_s;
  logic                    pop_s;
  logic                    last_hs_s;
  logic [INF_W-1:0]        inflight_s;
  logic [CNT_W-1:0]        count_after_pop_s;
  logic [CNT_W-1:0]        count_nxt_s;
  logic [PTR_W-1:0]        rd_ptr_nxt_s;
  logic [LEN_W-1:0]        beat_nxt_s;
  logic [DATA_WIDTH-1:0]   head_nxt_s;

  // Number of reads currently travelling through the RAM pipeline.
  function automatic logic [INF_W-1:0] count_tags(input logic [RD_LATENCY-1:0] tags);
    logic [INF_W-1:0] n;
    n = {INF_W{1'b0}};
    for (int i = 0; i < RD_LATENCY; i++) begin
      n = n + INF_W'(tags[i]);
    end
    return n;
  endfunction

  // Circular FIFO pointer advance; works for non-power-of-two depths too.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? {PTR_W{1'b0}} : (p + PTR_W'(1));
  endfunction

  // Issue credit, FIFO push/pop and the next-cycle view of the FIFO head.
  always_comb begin
    accept_s          = cmd_valid & cmd_ready_r;
    inflight_s        = count_tags(tag_r);
    issue_s           = (state_r == ST_RUN) && (issue_cnt_r != {LEN_W{1'b0}}) &&
                        ((SUM_W'(fifo_count_r) + SUM_W'(inflight_s)) < SUM_W'(FIFO_DEPTH));
    push_s            = tag_r[RD_LATENCY-1];
    pop_s             = valid_r & out_ready;
    last_hs_s         = pop_s & last_r;
    count_after_pop_s = fifo_count_r - CNT_W'(pop_s);
    count_nxt_s       = count_after_pop_s + CNT_W'(push_s);
    rd_ptr_nxt_s      = pop_s ? ptr_inc(rd_ptr_r) : rd_ptr_r;
    beat_nxt_s        = pop_s ? (beat_cnt_r - LEN_W'(1)) : beat_cnt_r;
    // When the FIFO would otherwise be empty the incoming word becomes the head.
    if (count_after_pop_s == {CNT_W{1'b0}}) begin
      head_nxt_s = ram_rd_data;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // Command FSM: accepts commands, walks the read address and owns cmd_ready/busy/done.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state_r     <= ST_IDLE;
      addr_r      <= {ADDR_WIDTH{1'b0}};
      issue_cnt_r <= {LEN_W{1'b0}};
      beat_cnt_r  <= {LEN_W{1'b0}};
      cmd_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            addr_r      <= cmd_addr;
            issue_cnt_r <= cmd_len;
            beat_cnt_r  <= cmd_len;
            cmd_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            if (cmd_len == {LEN_W{1'b0}}) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end else begin
              state_r <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          beat_cnt_r <= beat_nxt_s;
          if (issue_s) begin
            addr_r      <= addr_r + ADDR_WIDTH'(1);
            issue_cnt_r <= issue_cnt_r - LEN_W'(1);
            if (issue_cnt_r == LEN_W'(1)) begin
              state_r <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          beat_cnt_r <= beat_nxt_s;
          if (last_hs_s) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_r     <= ST_IDLE;
          done_r      <= 1'b0;
          busy_r      <= 1'b0;
          cmd_ready_r <= 1'b1;
        end
        default: begin
          state_r     <= ST_IDLE;
          done_r      <= 1'b0;
          busy_r      <= 1'b0;
          cmd_ready_r <= 1'b1;
        end
      endcase
    end
  end

  // Read-tag pipeline and prefetch FIFO with registered stream outputs.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      tag_r        <= {RD_LATENCY{1'b0}};
      wr_ptr_r     <= {PTR_W{1'b0}};
      rd_ptr_r     <= {PTR_W{1'b0}};
      fifo_count_r <= {CNT_W{1'b0}};
      valid_r      <= 1'b0;
      last_r       <= 1'b0;
      data_r       <= {DATA_WIDTH{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      tag_r <= (tag_r << 1) | RD_LATENCY'(issue_s);
      if (push_s) begin
        mem_r[wr_ptr_r] <= ram_rd_data;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      rd_ptr_r     <= rd_ptr_nxt_s;
      fifo_count_r <= count_nxt_s;
      valid_r      <= (count_nxt_s != {CNT_W{1'b0}});
      last_r       <= (count_nxt_s != {CNT_W{1'b0}}) && (beat_nxt_s == LEN_W'(1));
      data_r       <= head_nxt_s;
    end
  end

  assign cmd_ready   = cmd_ready_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign ram_rd_addr = addr_r;
  assign out_valid   = valid_r;
  assign out_last    = last_r;
  assign out_data    = data_r;

endmodule

// File: tb/tb_ipsl_pcie_ext_rcvd_ram_rd_ctrl.sv
// Directed bench for ipsl_pcie_ext_rcvd_ram_rd_ctrl with a 2-cycle RAM model (RAM[i]=i).
module tb_ipsl_pcie_ext_rcvd_ram_rd_ctrl;

  logic        clk = 1'b0;
  logic        rd_rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_addr;
  logic [10:0] cmd_len;
  logic [9:0]  ram_rd_addr;
  logic [71:0] ram_rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [71:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [71:0] ram_mem [1024];
  logic [71:0] ram_s1;
  logic [71:0] ram_s2;

  always #5 clk = ~clk;

  ipsl_pcie_ext_rcvd_ram_rd_ctrl dut (
    .rd_clk      (clk),
    .rd_rst      (rd_rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done)
  );

  // Two-stage registered RAM read port.
  always @(posedge clk) begin
    ram_s1 <= ram_mem[ram_rd_addr];
    ram_s2 <= ram_s1;
  end
  assign ram_rd_data = ram_s2;

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    else if (cyc < 20) return (cyc % 2) == 0;
    else if (cyc < 30) return 1'b0;
    else return 1'b1;
  endfunction

  // Called just after a negedge. mode 0: out_ready=1; mode 1: alternate then stall.
  // hold: cmd_valid stays asserted for the whole command.
  task automatic run_cmd(input int addr, input int len, input int mode, input bit hold);
    int idx, cyc, first_cyc, last_cyc, done_cyc, extra, exp_addr, occ;
    bit over;
    idx = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1; extra = 0; over = 1'b0;
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_addr  = addr[9:0];
    cmd_len   = len[10:0];
    out_ready = 1'b1;
    @(negedge clk);
    cyc = 1;
    if (!hold) cmd_valid = 1'b0;
    chk("busy_after_accept", busy, 1);
    while (cyc < 3000 && done_cyc < 0) begin
      out_ready = rdy(mode, cyc);
      if (hold && cmd_valid && cmd_ready) extra++;
      occ = int'(dut.fifo_count_r) + int'(dut.inflight_s);
      if (occ > 4) over = 1'b1;
      if (done) begin
        done_cyc = cyc;
        chk("valid_at_done", out_valid, 0);
      end else begin
        if (mode == 0 && cyc <= 5) begin
          exp_addr = (addr + ((cyc - 1 < len) ? cyc - 1 : len)) % 1024;
          chk("ram_rd_addr", ram_rd_addr, exp_addr);
        end
        if (mode == 1 && cyc == 29) begin
          chk("stall_addr_hold", ram_rd_addr, (addr + 12) % 1024);
          chk("stall_valid", out_valid, 1);
        end
        if (out_valid && first_cyc < 0) first_cyc = cyc;
        if (out_valid && out_ready) begin
          chk("data", out_data, (addr + idx) % 1024);
          chk("last", out_last, (idx == len - 1) ? 1 : 0);
          last_cyc = cyc;
          idx++;
        end
        @(negedge clk);
        cyc++;
      end
    end
    chk("done_seen", (done_cyc >= 0) ? 1 : 0, 1);
    chk("beat_count", idx, len);
    chk("credit_bound", over, 0);
    if (hold) chk("held_cmd_ignored", extra, 0);
    if (len == 0) begin
      chk("len0_no_valid", first_cyc, -1);
      chk("len0_done_cyc", done_cyc, 1);
    end else begin
      chk("done_after_last", done_cyc, last_cyc + 1);
      if (mode == 0) begin
        chk("first_valid_cyc", first_cyc, 4);
        chk("no_bubbles", last_cyc - first_cyc, len - 1);
      end
    end
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("cmd_ready_after", cmd_ready, 1);
    chk("busy_after", busy, 0);
  endtask

  initial begin
    int idx, seen;
    for (int i = 0; i < 1024; i++) ram_mem[i] = 72'(i);
    rd_rst    = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = 10'd0;
    cmd_len   = 11'd0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rd_rst = 1'b0;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_ram_rd_addr", ram_rd_addr, 0);
    chk("rst_out_data", out_data, 0);

    run_cmd(0, 4, 0, 1'b0);
    run_cmd(1022, 4, 0, 1'b0);
    run_cmd(200, 16, 1, 1'b0);
    run_cmd(5, 1024, 0, 1'b0);

    // Reset in the middle of a len=8 command after 3 beats.
    cmd_valid = 1'b1; cmd_addr = 10'd300; cmd_len = 11'd8; out_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    idx = 0;
    for (int c = 0; c < 20 && idx < 3; c++) begin
      if (out_valid && out_ready) begin
        chk("rst_pre_data", out_data, 300 + idx);
        idx++;
      end
      if (idx < 3) @(negedge clk);
    end
    chk("rst_pre_beats", idx, 3);
    @(negedge clk);
    rd_rst = 1'b1;
    @(negedge clk);
    rd_rst = 1'b0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", cmd_ready, 1);
    chk("mid_rst_done", done, 0);
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (done || out_valid) seen++;
      @(negedge clk);
    end
    chk("mid_rst_quiet", seen, 0);
    run_cmd(100, 2, 0, 1'b0);

    // Zero-length command, then a command held valid through busy.
    run_cmd(0, 0, 0, 1'b0);
    run_cmd(400, 3, 0, 1'b1);
    run_cmd(400, 3, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
